// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-client DRAM port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MARB_IDLE      = 2'd0,
    MARB_GRANT     = 2'd1,
    MARB_WAIT_RESP = 2'd2
  } marb_state_t;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_mux.sv
// Combinational client steering: 2:1 request mux toward DRAM, ready/valid demux back to the owner.
module mem_arb_mux
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_DATA_BITS = 128,
  parameter int MEM_ADDR_BITS = 28
) (
  input  logic                       sel,
  input  logic                       req_en,
  input  logic                       data_en,
  input  logic                       resp_en,
  input  logic                       ic_req_valid,
  input  logic                       ic_req_rw,
  input  logic [MEM_ADDR_BITS-1:0]   ic_req_addr,
  input  logic                       ic_data_valid,
  input  logic [MEM_DATA_BITS-1:0]   ic_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] ic_data_mask,
  input  logic                       dc_req_valid,
  input  logic                       dc_req_rw,
  input  logic [MEM_ADDR_BITS-1:0]   dc_req_addr,
  input  logic                       dc_data_valid,
  input  logic [MEM_DATA_BITS-1:0]   dc_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] dc_data_mask,
  output logic                       ic_req_ready,
  output logic                       ic_data_ready,
  output logic                       ic_resp_valid,
  output logic                       dc_req_ready,
  output logic                       dc_data_ready,
  output logic                       dc_resp_valid,
  output logic                       mem_req_valid,
  output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  output logic                       mem_req_rw,
  output logic                       mem_req_data_valid,
  output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                       mem_req_ready,
  input  logic                       mem_req_data_ready,
  input  logic                       mem_resp_valid,
  output logic                       sel_req_valid,
  output logic                       sel_rw
);

  logic is_dc;
  logic sel_data_valid;

  // Separate assigns keep the req_fire -> data_en feedback acyclic per signal.
  assign is_dc          = (sel == OWNER_DC);
  assign sel_req_valid  = is_dc ? dc_req_valid  : ic_req_valid;
  assign sel_rw         = is_dc ? dc_req_rw     : ic_req_rw;
  assign sel_data_valid = is_dc ? dc_data_valid : ic_data_valid;

  assign mem_req_valid      = req_en & sel_req_valid;
  assign mem_req_addr       = req_en ? (is_dc ? dc_req_addr : ic_req_addr) : '0;
  assign mem_req_rw         = req_en & sel_rw;
  assign mem_req_data_valid = data_en & sel_data_valid;
  assign mem_req_data_bits  = data_en ? (is_dc ? dc_data_bits : ic_data_bits) : '0;
  assign mem_req_data_mask  = data_en ? (is_dc ? dc_data_mask : ic_data_mask) : '0;

  assign ic_req_ready  = req_en  & ~is_dc & mem_req_ready;
  assign dc_req_ready  = req_en  &  is_dc & mem_req_ready;
  assign ic_data_ready = data_en & ~is_dc & mem_req_data_ready;
  assign dc_data_ready = data_en &  is_dc & mem_req_data_ready;
  assign ic_resp_valid = resp_en & ~is_dc & mem_resp_valid;
  assign dc_resp_valid = resp_en &  is_dc & mem_resp_valid;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner of the single DRAM port between icache and dcache, one whole transaction per grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_DATA_BITS = 128,
  parameter int MEM_ADDR_BITS = 28,
  parameter int READ_BEATS    = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ic_mem_req_valid,
  output logic                       ic_mem_req_ready,
  input  logic [MEM_ADDR_BITS-1:0]   ic_mem_req_addr,
  input  logic                       ic_mem_req_rw,
  input  logic                       ic_mem_req_data_valid,
  output logic                       ic_mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   ic_mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] ic_mem_req_data_mask,
  output logic                       ic_mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   ic_mem_resp_data,
  input  logic                       dc_mem_req_valid,
  output logic                       dc_mem_req_ready,
  input  logic [MEM_ADDR_BITS-1:0]   dc_mem_req_addr,
  input  logic                       dc_mem_req_rw,
  input  logic                       dc_mem_req_data_valid,
  output logic                       dc_mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   dc_mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] dc_mem_req_data_mask,
  output logic                       dc_mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   dc_mem_resp_data,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  output logic                       mem_req_rw,
  output logic                       mem_req_data_valid,
  input  logic                       mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                       mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,
  output logic                       proto_err
);

  localparam int BEAT_W = (ceil_log2(READ_BEATS) < 1) ? 1 : ceil_log2(READ_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(READ_BEATS - 1);

  marb_state_t       state;
  logic              owner;
  logic              last_owner;
  logic              req_done;
  logic              data_done;
  logic [BEAT_W-1:0] beat_cnt;

  logic grant_en, resp_en, req_en, data_en;
  logic req_fire, data_fire;
  logic sel_req_valid, sel_rw;
  logic winner;

  assign grant_en  = (state == MARB_GRANT);
  assign resp_en   = (state == MARB_WAIT_RESP);
  assign req_en    = grant_en & ~req_done;
  assign req_fire  = mem_req_valid & mem_req_ready;
  // Write data may go out with the request beat or after it, never before.
  assign data_en   = grant_en & ~data_done & (req_done | (req_fire & sel_rw));
  assign data_fire = mem_req_data_valid & mem_req_data_ready;

  // Tie goes to whoever did not finish the previous transaction.
  assign winner = (ic_mem_req_valid & dc_mem_req_valid) ? ~last_owner : dc_mem_req_valid;

  assign ic_mem_resp_data = mem_resp_data;
  assign dc_mem_resp_data = mem_resp_data;

  mem_arb_mux #(
    .MEM_DATA_BITS (MEM_DATA_BITS),
    .MEM_ADDR_BITS (MEM_ADDR_BITS)
  ) u_mux (
    .sel                (owner),
    .req_en             (req_en),
    .data_en            (data_en),
    .resp_en            (resp_en),
    .ic_req_valid       (ic_mem_req_valid),
    .ic_req_rw          (ic_mem_req_rw),
    .ic_req_addr        (ic_mem_req_addr),
    .ic_data_valid      (ic_mem_req_data_valid),
    .ic_data_bits       (ic_mem_req_data_bits),
    .ic_data_mask       (ic_mem_req_data_mask),
    .dc_req_valid       (dc_mem_req_valid),
    .dc_req_rw          (dc_mem_req_rw),
    .dc_req_addr        (dc_mem_req_addr),
    .dc_data_valid      (dc_mem_req_data_valid),
    .dc_data_bits       (dc_mem_req_data_bits),
    .dc_data_mask       (dc_mem_req_data_mask),
    .ic_req_ready       (ic_mem_req_ready),
    .ic_data_ready      (ic_mem_req_data_ready),
    .ic_resp_valid      (ic_mem_resp_valid),
    .dc_req_ready       (dc_mem_req_ready),
    .dc_data_ready      (dc_mem_req_data_ready),
    .dc_resp_valid      (dc_mem_resp_valid),
    .mem_req_valid      (mem_req_valid),
    .mem_req_addr       (mem_req_addr),
    .mem_req_rw         (mem_req_rw),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_req_data_mask  (mem_req_data_mask),
    .mem_req_ready      (mem_req_ready),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_resp_valid     (mem_resp_valid),
    .sel_req_valid      (sel_req_valid),
    .sel_rw             (sel_rw)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= MARB_IDLE;
      owner      <= OWNER_IC;
      last_owner <= OWNER_DC;
      req_done   <= 1'b0;
      data_done  <= 1'b0;
      beat_cnt   <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (mem_resp_valid && !resp_en) proto_err <= 1'b1;
      case (state)
        MARB_IDLE: begin
          if (ic_mem_req_valid || dc_mem_req_valid) begin
            owner <= winner;
            state <= MARB_GRANT;
          end
        end
        MARB_GRANT: begin
          if (!req_done && !sel_req_valid) begin
            // Withdrawn before acceptance: release without rotating priority.
            state <= MARB_IDLE;
          end else begin
            if (req_fire)  req_done  <= 1'b1;
            if (data_fire) data_done <= 1'b1;
            if (req_fire && !sel_rw) begin
              state    <= MARB_WAIT_RESP;
              beat_cnt <= '0;
              req_done <= 1'b0;
            end else if ((req_done || req_fire) && (data_done || data_fire)) begin
              state      <= MARB_IDLE;
              last_owner <= owner;
              req_done   <= 1'b0;
              data_done  <= 1'b0;
            end
          end
        end
        MARB_WAIT_RESP: begin
          if (mem_resp_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt   <= '0;
              state      <= MARB_IDLE;
              last_owner <= owner;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        default: state <= MARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, rotation, write data timing, async reset, protocol error flag.
module tb_mem_arbiter;

  localparam int DW = 128;
  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ic_mem_req_valid, ic_mem_req_ready, ic_mem_req_rw;
  logic [AW-1:0] ic_mem_req_addr;
  logic          ic_mem_req_data_valid, ic_mem_req_data_ready;
  logic [DW-1:0] ic_mem_req_data_bits;
  logic [DW/8-1:0] ic_mem_req_data_mask;
  logic          ic_mem_resp_valid;
  logic [DW-1:0] ic_mem_resp_data;
  logic          dc_mem_req_valid, dc_mem_req_ready, dc_mem_req_rw;
  logic [AW-1:0] dc_mem_req_addr;
  logic          dc_mem_req_data_valid, dc_mem_req_data_ready;
  logic [DW-1:0] dc_mem_req_data_bits;
  logic [DW/8-1:0] dc_mem_req_data_mask;
  logic          dc_mem_resp_valid;
  logic [DW-1:0] dc_mem_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0] mem_req_data_bits;
  logic [DW/8-1:0] mem_req_data_mask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic          proto_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_data_fire = 0;
  int fire_base;

  localparam logic [DW-1:0] DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset_n && mem_req_data_valid && mem_req_data_ready) n_data_fire <= n_data_fire + 1;

  mem_arbiter #(.MEM_DATA_BITS(DW), .MEM_ADDR_BITS(AW), .READ_BEATS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ic_mem_req_valid(ic_mem_req_valid), .ic_mem_req_ready(ic_mem_req_ready),
    .ic_mem_req_addr(ic_mem_req_addr), .ic_mem_req_rw(ic_mem_req_rw),
    .ic_mem_req_data_valid(ic_mem_req_data_valid), .ic_mem_req_data_ready(ic_mem_req_data_ready),
    .ic_mem_req_data_bits(ic_mem_req_data_bits), .ic_mem_req_data_mask(ic_mem_req_data_mask),
    .ic_mem_resp_valid(ic_mem_resp_valid), .ic_mem_resp_data(ic_mem_resp_data),
    .dc_mem_req_valid(dc_mem_req_valid), .dc_mem_req_ready(dc_mem_req_ready),
    .dc_mem_req_addr(dc_mem_req_addr), .dc_mem_req_rw(dc_mem_req_rw),
    .dc_mem_req_data_valid(dc_mem_req_data_valid), .dc_mem_req_data_ready(dc_mem_req_data_ready),
    .dc_mem_req_data_bits(dc_mem_req_data_bits), .dc_mem_req_data_mask(dc_mem_req_data_mask),
    .dc_mem_resp_valid(dc_mem_resp_valid), .dc_mem_resp_data(dc_mem_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Four response beats 0xA..0xD; only the owner sees them, the other client stays stalled.
  task automatic run_beats(input logic to_dc);
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = DW'(32'hA + k);
      #2;
      chk("beat_ic_valid", ic_mem_resp_valid, !to_dc);
      chk("beat_dc_valid", dc_mem_resp_valid, to_dc);
      chk("beat_data", to_dc ? dc_mem_resp_data : ic_mem_resp_data, DW'(32'hA + k));
      chk("beat_other_ready", to_dc ? ic_mem_req_ready : dc_mem_req_ready, 1'b0);
      chk("beat_mem_req_valid", mem_req_valid, 1'b0);
      step();
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic both_round(input logic exp_dc);
    ic_mem_req_valid = 1'b1; ic_mem_req_rw = 1'b0; ic_mem_req_addr = 28'h0000111;
    dc_mem_req_valid = 1'b1; dc_mem_req_rw = 1'b0; dc_mem_req_addr = 28'h0000222;
    step(); #2;
    chk("rr_ic_ready", ic_mem_req_ready, !exp_dc);
    chk("rr_dc_ready", dc_mem_req_ready, exp_dc);
    chk("rr_addr", mem_req_addr, exp_dc ? 28'h0000222 : 28'h0000111);
    step();
    ic_mem_req_valid = 1'b0;
    dc_mem_req_valid = 1'b0;
    run_beats(exp_dc);
  endtask

  initial begin
    reset_n = 1'b0;
    ic_mem_req_valid = 0; ic_mem_req_addr = '0; ic_mem_req_rw = 0;
    ic_mem_req_data_valid = 0; ic_mem_req_data_bits = '0; ic_mem_req_data_mask = '0;
    dc_mem_req_valid = 0; dc_mem_req_addr = '0; dc_mem_req_rw = 0;
    dc_mem_req_data_valid = 0; dc_mem_req_data_bits = '0; dc_mem_req_data_mask = '0;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    #3;
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_ic_ready", ic_mem_req_ready, 1'b0);
    chk("rst_dc_ready", dc_mem_req_ready, 1'b0);
    chk("rst_data_valid", mem_req_data_valid, 1'b0);
    chk("rst_proto_err", proto_err, 1'b0);
    #19 reset_n = 1'b1;

    // ic read, one-cycle grant latency
    step();
    ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000100; ic_mem_req_rw = 1'b0;
    #2;
    chk("rd_latency", mem_req_valid, 1'b0);
    step(); #2;
    chk("rd_valid", mem_req_valid, 1'b1);
    chk("rd_addr", mem_req_addr, 28'h0000100);
    chk("rd_rw", mem_req_rw, 1'b0);
    chk("rd_ic_ready", ic_mem_req_ready, 1'b1);
    chk("rd_dc_ready", dc_mem_req_ready, 1'b0);
    step();
    ic_mem_req_valid = 1'b0;
    run_beats(1'b0);
    chk("rd_no_err", proto_err, 1'b0);

    // dc write, data accepted two cycles after the request
    mem_req_data_ready = 1'b0;
    dc_mem_req_valid = 1'b1; dc_mem_req_rw = 1'b1; dc_mem_req_addr = 28'h0000200;
    dc_mem_req_data_valid = 1'b1; dc_mem_req_data_bits = DEAD; dc_mem_req_data_mask = 16'hFFFF;
    step(); #2;
    fire_base = n_data_fire;
    chk("wr_valid", mem_req_valid, 1'b1);
    chk("wr_rw", mem_req_rw, 1'b1);
    chk("wr_addr", mem_req_addr, 28'h0000200);
    chk("wr_data_valid_same", mem_req_data_valid, 1'b1);
    chk("wr_dc_ready", dc_mem_req_ready, 1'b1);
    chk("wr_ic_ready", ic_mem_req_ready, 1'b0);
    step();
    dc_mem_req_valid = 1'b0;
    #2;
    chk("wr_req_dropped", mem_req_valid, 1'b0);
    chk("wr_data_held", mem_req_data_valid, 1'b1);
    chk("wr_dc_data_ready0", dc_mem_req_data_ready, 1'b0);
    step();
    mem_req_data_ready = 1'b1;
    #2;
    chk("wr_dc_data_ready", dc_mem_req_data_ready, 1'b1);
    chk("wr_ic_data_ready", ic_mem_req_data_ready, 1'b0);
    chk("wr_bits", mem_req_data_bits, DEAD);
    chk("wr_mask", mem_req_data_mask, 16'hFFFF);
    step();
    dc_mem_req_data_valid = 1'b0;
    #2;
    chk("wr_one_fire", n_data_fire - fire_base, 1);
    chk("wr_idle_data", mem_req_data_valid, 1'b0);
    chk("wr_idle_ready", dc_mem_req_ready, 1'b0);

    // async reset in the middle of beat 2 of an ic read
    ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000100; ic_mem_req_rw = 1'b0;
    step();
    step();
    ic_mem_req_valid = 1'b0;
    mem_resp_valid = 1'b1;
    step();
    step();
    #1;
    chk("pre_rst_resp", ic_mem_resp_valid, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_ic_resp", ic_mem_resp_valid, 1'b0);
    chk("arst_dc_resp", dc_mem_resp_valid, 1'b0);
    chk("arst_mem_req_valid", mem_req_valid, 1'b0);
    chk("arst_ic_ready", ic_mem_req_ready, 1'b0);
    chk("arst_proto_err", proto_err, 1'b0);
    mem_resp_valid = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;

    // round robin from reset: ic, dc, ic
    both_round(1'b0);
    both_round(1'b1);
    both_round(1'b0);

    // dc arrives during ic's transaction and waits for it to finish
    ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000300; ic_mem_req_rw = 1'b0;
    step(); #2;
    chk("hold_ic_ready", ic_mem_req_ready, 1'b1);
    step();
    ic_mem_req_valid = 1'b0;
    dc_mem_req_valid = 1'b1; dc_mem_req_addr = 28'h0000400; dc_mem_req_rw = 1'b0;
    run_beats(1'b0);
    #2;
    chk("hold_gap_ready", dc_mem_req_ready, 1'b0);
    chk("hold_gap_valid", mem_req_valid, 1'b0);
    step(); #2;
    chk("hold_dc_granted", dc_mem_req_ready, 1'b1);
    chk("hold_dc_addr", mem_req_addr, 28'h0000400);
    step();
    dc_mem_req_valid = 1'b0;
    run_beats(1'b1);

    // stray response while idle
    mem_resp_valid = 1'b1;
    #2;
    chk("stray_ic_resp", ic_mem_resp_valid, 1'b0);
    chk("stray_dc_resp", dc_mem_resp_valid, 1'b0);
    step();
    mem_resp_valid = 1'b0;
    #2;
    chk("proto_err_set", proto_err, 1'b1);
    repeat (3) step();
    chk("proto_err_sticky", proto_err, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("proto_err_cleared", proto_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
